// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the matrix-datapath SRAM arbiter and its requesters.
package sram_arb_pkg;

    typedef enum logic {
        S_ARB_OPEN   = 1'b0,
        S_ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 18;

    // Matrix regions in SRAM, shared by compute, display and debug requesters
    localparam int MAT_A_BASE = 0;
    localparam int MAT_B_BASE = 16;
    localparam int MAT_C_BASE = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);

    always_comb begin
        int idx;
        gnt = '0;
        any = 1'b0;
        idx = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter with lock for the single-port matrix SRAM; registered SRAM port,
// fixed two-cycle read return with a per-requester valid strobe.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PTR_W      = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               lock,
    input  logic [NUM_REQ-1:0]               we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic                             sram_en,
    output logic                             sram_we,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [DATA_WIDTH-1:0]            sram_din,
    input  logic [DATA_WIDTH-1:0]            sram_dout
);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, owner_q, owner_d, win;
    logic [NUM_REQ-1:0] pick_gnt, gnt_c;
    logic               pick_any, locked_hold, grant;
    logic               vld_p1, vld_p2;
    logic [PTR_W-1:0]   idx_p1, idx_p2;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_REQ - 1)) return '0;
        else                          return p + 1'b1;
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Stage p0: arbitration. A dropped lock arbitrates as open in the same cycle.
    always_comb begin
        locked_hold = (state_q == S_ARB_LOCKED) && lock[owner_q];
        win         = '0;
        gnt_c       = '0;
        if (locked_hold) begin
            win            = owner_q;
            gnt_c[owner_q] = req[owner_q];
        end else begin
            gnt_c = pick_gnt;
            for (int i = 0; i < NUM_REQ; i++)
                if (pick_gnt[i]) win = PTR_W'(i);
        end
    end

    assign grant = reset_n && (locked_hold ? req[owner_q] : pick_any);
    assign gnt   = reset_n ? gnt_c : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (grant) ptr_d = next_ptr(win);
        if (!locked_hold) begin
            state_d = S_ARB_OPEN;
            if (grant && lock[win]) begin
                state_d = S_ARB_LOCKED;
                owner_d = win;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ARB_OPEN;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Stage p1: SRAM port registers and read tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            vld_p1    <= 1'b0;
            idx_p1    <= '0;
        end else begin
            sram_en <= grant;
            sram_we <= grant && we[win];
            vld_p1  <= grant && !we[win];
            if (grant) begin
                sram_addr <= addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                sram_din  <= wdata[win*DATA_WIDTH +: DATA_WIDTH];
                idx_p1    <= win;
            end
        end
    end

    // Stage p2: read data return
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            idx_p2 <= '0;
            rdata  <= '0;
        end else begin
            vld_p2 <= vld_p1;
            idx_p2 <= idx_p1;
            if (vld_p1) rdata <= sram_dout;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rvalid[i] = vld_p2 && (idx_p2 == PTR_W'(i));
    end

    assign busy = sram_en | vld_p2;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: reset checks, grant table, hand-written corner sequences and
// randomized traffic against a grant-order memory reference model.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req, lock, we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt, rvalid;
    logic [DW-1:0]     rdata, sram_din, sram_dout;
    logic              busy, sram_en, sram_we;
    logic [AW-1:0]     sram_addr;

    always #5 clk = ~clk;

    sram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .busy(busy), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Flow-through SRAM: output follows the registered address, writes commit on the edge
    logic [DW-1:0] mem [0:2047];
    logic          pl_we;
    logic [AW-1:0] pl_a;
    logic [DW-1:0] pl_d;
    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (sram_en && sram_we) mem[sram_addr] <= sram_din;
    end
    assign sram_dout = mem[sram_addr];

    // Reference model: arbitration rules plus a grant-ordered memory image
    logic [DW-1:0] gold [0:2047];
    int        m_ptr, m_owner;
    bit        m_locked;
    bit        s1_g, s1_rd, s1_we, s2_rd;
    int        s1_idx, s2_idx;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_din, s1_data, s2_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] exp_gnt;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [DW-1:0] pat(input int i);
        if (i == 5) return 18'h0002A;
        else        return DW'(i * 1237 + 91);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_locked = 0;
        s1_g = 0; s1_rd = 0; s1_we = 0; s2_rd = 0;
        s1_idx = 0; s2_idx = 0;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge
    task automatic do_cycle();
        logic [N-1:0] eg;
        int  w;
        bit  g, hold;
        logic [AW-1:0] a;
        @(negedge clk);
        eg = '0; w = 0; g = 0;
        hold = m_locked && lock[m_owner];
        if (hold) begin
            if (req[m_owner]) begin g = 1; w = m_owner; end
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!g && req[j]) begin g = 1; w = j; end
            end
        end
        if (g) eg[w] = 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        check("sram_en", 32'(sram_en), 32'(s1_g));
        check("sram_we", 32'(sram_we), 32'(s1_g && s1_we));
        if (s1_g) begin
            check("sram_addr", 32'(sram_addr), 32'(s1_addr));
            if (s1_we) check("sram_din", 32'(sram_din), 32'(s1_din));
        end
        check("busy", 32'(busy), 32'(s1_g || s2_rd));
        check("rvalid", 32'(rvalid), s2_rd ? (32'd1 << s2_idx) : 32'd0);
        if (s2_rd) check("rdata", 32'(rdata), 32'(s2_data));
        @(posedge clk);
        s2_rd = s1_rd; s2_idx = s1_idx; s2_data = s1_data;
        s1_g = g; s1_rd = 0; s1_we = 0;
        if (g) begin
            a       = addr[w*AW +: AW];
            s1_we   = we[w];
            s1_rd   = !we[w];
            s1_idx  = w;
            s1_addr = a;
            s1_din  = wdata[w*DW +: DW];
            s1_data = gold[a];
            if (we[w]) gold[a] = wdata[w*DW +: DW];
            m_ptr = (w + 1) % N;
        end
        if (!hold) begin
            m_locked = g && lock[w];
            m_owner  = w;
        end
        #1;
    endtask

    initial begin
        // contention: rotation 0,1,2,0,1,2
        for (int i = 0; i < 6; i++)
            tbl.push_back('{req: 3'b111, lock: 3'b000, exp_gnt: 3'b001 << (i % 3)});
        // lock[0] for four accesses while req[2] waits, then 2 wins when the lock drops
        for (int i = 0; i < 4; i++)
            tbl.push_back('{req: 3'b101, lock: 3'b001, exp_gnt: 3'b001});
        tbl.push_back('{req: 3'b101, lock: 3'b000, exp_gnt: 3'b100});
        tbl.push_back('{req: 3'b000, lock: 3'b000, exp_gnt: 3'b000});
        // lock without a grant has no effect
        tbl.push_back('{req: 3'b000, lock: 3'b010, exp_gnt: 3'b000});
        tbl.push_back('{req: 3'b010, lock: 3'b000, exp_gnt: 3'b010});
        tbl.push_back('{req: 3'b110, lock: 3'b000, exp_gnt: 3'b100});
        // owner holding lock with no request idles the port
        tbl.push_back('{req: 3'b001, lock: 3'b001, exp_gnt: 3'b001});
        tbl.push_back('{req: 3'b100, lock: 3'b001, exp_gnt: 3'b000});
        tbl.push_back('{req: 3'b100, lock: 3'b000, exp_gnt: 3'b100});

        reset_n = 1'b0; req = '1; lock = '0; we = '0; addr = '0; wdata = '0;
        pl_we = 1'b1; pl_a = '0; pl_d = '0;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            pl_a = AW'(i); pl_d = pat(i); gold[i] = pat(i);
            @(posedge clk); #1;
        end
        pl_we = 1'b0;
        @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_sram_en", 32'(sram_en), 32'd0);
        check("reset_sram_we", 32'(sram_we), 32'd0);
        check("reset_sram_addr", 32'(sram_addr), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req = '0; reset_n = 1'b1;

        set_port(0, 11'h005, '0); set_port(1, 11'h006, '0); set_port(2, 11'h007, '0);
        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req; lock = tbl[i].lock; we = '0;
            #1;
            check($sformatf("tbl_gnt[%0d]", i), 32'(gnt), 32'(tbl[i].exp_gnt));
            do_cycle();
        end
        req = '0; lock = '0;
        repeat (3) do_cycle();

        // single read of word 5
        req = 3'b001; set_port(0, 11'h005, '0);
        do_cycle();
        req = '0;
        check("rd_sram_addr", 32'(sram_addr), 32'h005);
        check("rd_sram_en", 32'(sram_en), 32'd1);
        do_cycle();
        check("rd_rvalid", 32'(rvalid), 32'b001);
        check("rd_rdata", 32'(rdata), 32'h0002A);
        do_cycle();

        // write then read from requester 1
        req = 3'b010; we = 3'b010; set_port(1, 11'h020, 18'h3FFFF);
        do_cycle();
        we = '0;
        do_cycle();
        req = '0;
        do_cycle();
        check("wr_rd_rvalid", 32'(rvalid), 32'b010);
        check("wr_rd_rdata", 32'(rdata), 32'h3FFFF);
        do_cycle();

        // reset pulse one cycle after a read grant
        req = 3'b001; set_port(0, 11'h005, '0);
        do_cycle();
        req = '0;
        reset_n = 1'b0;
        #2;
        check("rst_mid_sram_en", 32'(sram_en), 32'd0);
        reset_n = 1'b1;
        model_reset();
        do_cycle();
        do_cycle();
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        req = 3'b111;
        #1;
        check("rst_mid_ptr", 32'(gnt), 32'b001);
        do_cycle();
        req = '0;
        repeat (3) do_cycle();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            we  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                lock[i] = ($urandom_range(0, 3) == 0);
                set_port(i, AW'($urandom_range(0, 63)), DW'($urandom));
            end
            do_cycle();
        end
        req = '0; lock = '0;
        repeat (4) do_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
